// File: rtl/arb_pkg.sv
// Shared types and constants for the unified IF/MEM memory-port arbiter.
// The access-size encodings are also used by the MEM stage when building dm_size.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] max);
    return (cur >= max) ? max : cur + 4'd1;
  endfunction

endpackage

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, one
// transaction at a time; data wins by default but fetch gets bounded starvation.
module imem_dmem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AWIDTH        = 32,
  parameter int DWIDTH        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  input  logic              if_kill,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AWIDTH-1:0] dm_addr,
  input  logic [DWIDTH-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  output logic [DWIDTH-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic              killed_q, killed_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_size_q, mem_size_d;

  logic if_eligible;
  logic if_wins;
  logic rsp_fire;

  // A fetch that is being killed this very cycle must not win the port.
  assign if_eligible = if_req & ~if_kill;
  assign if_wins     = if_eligible & (~dm_req | (streak_q == STREAK_MAX));
  assign rsp_fire    = (state_q == WAIT) & mem_rvalid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    killed_d    = killed_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;

    if ((owner_q == OWN_IF) && (state_q != IDLE) && if_kill) begin
      killed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (if_eligible || dm_req) begin
          state_d   = ISSUE;
          mem_req_d = 1'b1;
          killed_d  = 1'b0;
          if (if_wins) begin
            owner_d     = OWN_IF;
            streak_d    = 4'd0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_size_d  = MEM_SIZE_W;
          end else begin
            owner_d     = OWN_DM;
            streak_d    = if_req ? streak_inc(streak_q, STREAK_MAX) : 4'd0;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_size_d  = dm_size;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d     = WAIT;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_size_d  = 2'd0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d  = IDLE;
          owner_d  = OWN_NONE;
          killed_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      streak_q    <= 4'd0;
      killed_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      killed_q    <= killed_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
    end
  end

  // A kill arriving in the response cycle still discards that fetch.
  assign if_valid = rsp_fire & (owner_q == OWN_IF) & ~killed_q & ~if_kill;
  assign dm_valid = rsp_fire & (owner_q == OWN_DM);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one unified memory port between the IF-stage fetch requester and the MEM-stage load/store requester of the 5-stage core.
- Holds the port for exactly one transaction at a time.
- Sequences the issue/grant/response handshake to the memory.
- Produces per-requester stall signals that feed the pipeline stall/flush logic next to the hazard unit.
- Has a bounded-starvation policy: data accesses win by default, and fetch is guaranteed progress.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits (range 1-15)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid or if_kill
- if_addr  in  AWIDTH  fetch address
- if_kill  in  1  one-cycle pulse: branch/jump taken, discard current fetch
- if_rdata  out  DWIDTH  fetched instruction
- if_valid  out  1  one-cycle fetch completion
- if_stall  out  1  fetch not completing this cycle
- dm_req  in  1  data request; held with all dm_* inputs stable until dm_valid
- dm_we  in  1  1=store, 0=load
- dm_addr  in  AWIDTH  data address
- dm_wdata  in  DWIDTH  store data
- dm_size  in  2  0=byte, 1=half, 2=word
- dm_rdata  out  DWIDTH  load data
- dm_valid  out  1  one-cycle data completion (load or store)
- dm_stall  out  1  data access not completing this cycle
- mem_req  out  1  request to memory; held until mem_gnt
- mem_we  out  1  memory write enable
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_size  out  2  memory access size
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  response/ack; earliest one cycle after mem_gnt
- mem_rdata  in  DWIDTH  response data

Behaviour:
- Reset: state=IDLE, owner=NONE, streak=0, killed=0. All outputs 0 (mem_* registered, zero).
- FSM states:
  - IDLE: arbitrate when any request is present.
  - ISSUE: mem_req=1 with the owner's registered fields; on mem_gnt go to WAIT.
  - WAIT: mem_req=0; on mem_rvalid go to IDLE.
- Arbitration (IDLE only, registered into ISSUE):
  - Both requesting: IF wins if streak==MAX_DM_STREAK, else DM wins.
  - Single request: that requester wins.
  - An if_req in the same cycle as if_kill is not eligible.
- Streak counter:
  - Increments (saturating) on each DM grant made while if_req is high.
  - Clears on an IF grant, or on a DM grant with if_req low.
- Completion:
  - On mem_rvalid, the owner's valid pulses combinationally that cycle; rdata passes mem_rdata through.
  - Minimum latency: request cycle 0, mem_req cycle 1, gnt cycle 1, rvalid/valid cycle 2. Next arbitration is in cycle 3.
- Stalls: if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid. Killed or ineligible fetches are included.
- Kill:
  - if_kill while IF owns (ISSUE or WAIT) sets killed=1.
  - The memory transaction still completes, but if_valid is suppressed. killed clears on return to IDLE.
  - if_kill with DM as owner has no effect.
- Stores complete on mem_rvalid. dm_rdata is don't-care for stores; drive it as mem_rdata.
- Out-of-protocol responses: mem_rvalid in IDLE or ISSUE is ignored, with no valid pulse. mem_gnt outside ISSUE is ignored.
- Reset mid-transaction: FSM to IDLE immediately, mem_req drops. The late mem_rvalid is ignored (IDLE rule).
- Address/size alignment is not checked here; the downstream memory handles it.

Decomposition:
- Shared package arb_pkg:
  - enum arb_state_e {IDLE, ISSUE, WAIT}
  - enum arb_owner_e {OWN_NONE, OWN_IF, OWN_DM}
  - MEM_SIZE_B/H/W constants, shared with the MEM stage
- No sub-module. Optional leaf: arb_streak_counter (saturating counter with clear), if reuse is wanted.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x0100_0000, mem_gnt in cycle 1, rvalid with 0x00000013 in cycle 2 → if_valid=1 and if_rdata=0x13 in cycle 2; if_stall=1 in cycles 0-1.
- Contention: if_req and dm_req (load 0x0100_2000) both at cycle 0 → DM issues first. After dm_valid, IF issues next. mem_addr sequence is 0x0100_2000 then the fetch address.
- Starvation bound, MAX_DM_STREAK=4: dm_req held high for back-to-back loads with if_req high → exactly 4 DM grants, then an IF grant, then streak=0.
- Kill: IF owns and is in WAIT with 3-cycle memory latency; if_kill pulses → no if_valid on rvalid. The next if_req at 0x0100_0040 completes normally.
- Store ack: dm_we=1, dm_wdata=0xDEADBEEF, dm_size=2 → mem_we=1, mem_wdata=0xDEADBEEF, mem_size=2 while mem_req is high; dm_valid on the ack.
- Reset in WAIT: assert reset for 1 cycle, then a stale mem_rvalid arrives → no valid pulse, all outputs 0, and a fresh request issues normally.
